vga_buffer_ctrl: RTL and testbench

Sequencer and port controller for the 320x240x12-bit VGA frame buffer RAM.
- Write side: accepts the raster-order masked-pixel stream from the masking pipeline over a valid/ready handshake and generates the write row/col addresses and write enable.
- Read side: serves display-scan fetches with fixed latency and blanks the output while no complete frame is held.
- Frame status: start/done/valid signalling for the top-level sequencer.

---
 rtl/vga_buf_pkg.sv | 19 +
 rtl/vga_buffer_ctrl_if.sv | 40 ++++
 rtl/vga_buffer_ctrl_raster_addr_gen.sv | 45 ++++
 rtl/vga_buffer_ctrl.sv | 126 ++++++++++++
 tb/tb_vga_buffer_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_buf_pkg.sv
// Shared constants and FSM encoding for the VGA frame buffer, its RAM and
// the masking pipeline that feeds it.
package vga_buf_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int DATA_W = 12;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 9;

  localparam logic [DATA_W-1:0] BLANK = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_buffer_ctrl_if.sv
// Pipeline, RAM and display signals of the frame buffer controller.
// Handshake: a pixel transfers on a rising edge where in_valid & in_ready are both 1.
interface vga_buffer_ctrl_if;
  import vga_buf_pkg::*;

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ROW_W-1:0]  ram_wr_row;
  logic [COL_W-1:0]  ram_wr_col;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ROW_W-1:0]  ram_rd_row;
  logic [COL_W-1:0]  ram_rd_col;
  logic [DATA_W-1:0] ram_rd_data;
  logic              disp_req;
  logic [ROW_W-1:0]  disp_row;
  logic [COL_W-1:0]  disp_col;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_pixel;
  logic              busy;
  logic              frame_done;
  logic              frame_valid;

  modport slave (
    input  start, in_valid, in_data, ram_rd_data, disp_req, disp_row, disp_col,
    output in_ready, ram_we, ram_wr_row, ram_wr_col, ram_wr_data,
           ram_rd_row, ram_rd_col, disp_valid, disp_pixel,
           busy, frame_done, frame_valid
  );

  modport master (
    output start, in_valid, in_data, ram_rd_data, disp_req, disp_row, disp_col,
    input  in_ready, ram_we, ram_wr_row, ram_wr_col, ram_wr_data,
           ram_rd_row, ram_rd_col, disp_valid, disp_pixel,
           busy, frame_done, frame_valid
  );

endinterface

// File: rtl/vga_buffer_ctrl_raster_addr_gen.sv
// Raster-order row/col counter with clear, enable and wrap; o_last flags
// the final pixel of the frame so the owner can close out the frame.
module raster_addr_gen
  import vga_buf_pkg::*;
#(
  parameter int W = IMG_W,
  parameter int H = IMG_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  localparam logic [ROW_W-1:0] LP_ROW_MAX = ROW_W'(H - 1);
  localparam logic [COL_W-1:0] LP_COL_MAX = COL_W'(W - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == LP_COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == LP_ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == LP_ROW_MAX) && (r_col == LP_COL_MAX);

endmodule

// File: rtl/vga_buffer_ctrl.sv
// Frame buffer port controller: sequences raster writes from the masking
// pipeline and serves fixed two-cycle display fetches, blanking invalid reads.
module vga_buffer_ctrl
  import vga_buf_pkg::*;
#(
  parameter int FRAME_W = IMG_W,
  parameter int FRAME_H = IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  vga_buffer_ctrl_if.slave   bus,
  output state_t             o_state
);

  localparam logic [ROW_W-1:0] LP_ROWS = ROW_W'(FRAME_H);
  localparam logic [COL_W-1:0] LP_COLS = COL_W'(FRAME_W);

  state_t r_state, w_next;

  logic             w_fill, w_accept, w_clr, w_last;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  logic              r_we, r_frame_done, r_frame_valid;
  logic [ROW_W-1:0]  r_wr_row;
  logic [COL_W-1:0]  r_wr_col;
  logic [DATA_W-1:0] r_wr_data;

  logic [ROW_W-1:0]  r_rd_row;
  logic [COL_W-1:0]  r_rd_col;
  logic              r_req1, r_blank1, r_req2, r_blank2;
  logic [DATA_W-1:0] r_pix_hold;
  logic [DATA_W-1:0] w_disp_pixel;

  assign w_fill   = (r_state == ST_FILL);
  assign w_accept = bus.in_valid & w_fill;
  // A start only counts when it actually moves the FSM into FILL.
  assign w_clr    = bus.start & ~w_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)         w_next = ST_FILL;
      ST_FILL: if (w_accept & w_last) w_next = ST_DONE;
      ST_DONE: if (bus.start)         w_next = ST_FILL;
      default:                        w_next = ST_IDLE;
    endcase
  end

  raster_addr_gen #(.W(FRAME_W), .H(FRAME_H)) u_wr_addr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_accept),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we          <= 1'b0;
      r_wr_row      <= '0;
      r_wr_col      <= '0;
      r_wr_data     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_we         <= w_accept;
      r_frame_done <= w_accept & w_last;
      if (w_accept) begin
        r_wr_row  <= w_row;
        r_wr_col  <= w_col;
        r_wr_data <= bus.in_data;
      end
      // A restart wins over a completion landing in the same cycle.
      if (w_clr)             r_frame_valid <= 1'b0;
      else if (r_frame_done) r_frame_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_row   <= '0;
      r_rd_col   <= '0;
      r_req1     <= 1'b0;
      r_blank1   <= 1'b0;
      r_req2     <= 1'b0;
      r_blank2   <= 1'b0;
      r_pix_hold <= '0;
    end else begin
      r_req1 <= bus.disp_req;
      if (bus.disp_req) begin
        r_rd_row <= bus.disp_row;
        r_rd_col <= bus.disp_col;
        r_blank1 <= ~r_frame_valid | (bus.disp_row >= LP_ROWS) | (bus.disp_col >= LP_COLS);
      end
      r_req2   <= r_req1;
      r_blank2 <= r_blank1;
      if (r_req2) r_pix_hold <= w_disp_pixel;
    end
  end

  // RAM data arrives registered in the third cycle; pass it straight through then.
  assign w_disp_pixel = r_req2 ? (r_blank2 ? BLANK : bus.ram_rd_data) : r_pix_hold;

  assign bus.in_ready    = w_fill;
  assign bus.busy        = w_fill;
  assign bus.ram_we      = r_we;
  assign bus.ram_wr_row  = r_wr_row;
  assign bus.ram_wr_col  = r_wr_col;
  assign bus.ram_wr_data = r_wr_data;
  assign bus.ram_rd_row  = r_rd_row;
  assign bus.ram_rd_col  = r_rd_col;
  assign bus.disp_valid  = r_req2;
  assign bus.disp_pixel  = w_disp_pixel;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_valid = r_frame_valid;
  assign o_state         = r_state;

endmodule

// File: tb/tb_vga_buffer_ctrl.sv
// Directed bench for vga_buffer_ctrl on a reduced 16x8 frame with a
// behavioural 1-cycle-latency RAM attached to the controller's ports.
module tb_vga_buffer_ctrl;
  import vga_buf_pkg::*;

  localparam int TW   = 16;
  localparam int TH   = 8;
  localparam int NPIX = TW * TH;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_fail   = 0;

  vga_buffer_ctrl_if bif ();

  vga_buffer_ctrl #(.FRAME_W(TW), .FRAME_H(TH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif.slave),
    .o_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: synchronous write, registered read
  logic [DATA_W-1:0] mem [0:TH-1][0:TW-1];
  always @(posedge clk) begin
    if (bif.ram_we && int'(bif.ram_wr_row) < TH && int'(bif.ram_wr_col) < TW)
      mem[int'(bif.ram_wr_row)][int'(bif.ram_wr_col)] <= bif.ram_wr_data;
    if (int'(bif.ram_rd_row) < TH && int'(bif.ram_rd_col) < TW)
      bif.ram_rd_data <= mem[int'(bif.ram_rd_row)][int'(bif.ram_rd_col)];
    else
      bif.ram_rd_data <= 12'hABC;
  end

  function automatic logic [DATA_W-1:0] pix(input int r, input int c);
    logic [31:0] rr, cc;
    rr = r;
    cc = c;
    return {rr[3:0], cc[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n beats of a frame starting at pixel 0; every accepted beat's write is checked.
  task automatic run_fill(input bit gaps, input int n, input bit start_mid,
                          input bit start_last, input logic [DATA_W-1:0] xmask);
    for (int k = 0; k < n; k++) begin
      int r, c;
      r = k / TW;
      c = k % TW;
      if (gaps && (k % 2 == 1)) begin
        bif.in_valid = 1'b0;
        tick();
        chk("gap_we", bif.ram_we, 0);
        chk("gap_col_hold", bif.ram_wr_col, (k - 1) % TW);
      end
      bif.in_valid = 1'b1;
      bif.in_data  = pix(r, c) ^ xmask;
      bif.start    = (start_mid && k == NPIX / 2) || (start_last && k == NPIX - 1);
      tick();
      bif.start = 1'b0;
      chk("wr_we", bif.ram_we, 1);
      chk("wr_row", bif.ram_wr_row, r);
      chk("wr_col", bif.ram_wr_col, c);
      chk("wr_data", bif.ram_wr_data, pix(r, c) ^ xmask);
      chk("frame_done", bif.frame_done, (k == NPIX - 1) ? 1 : 0);
    end
    bif.in_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bif.start    = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = 12'hFFF;
    bif.disp_req = 1'b0;
    bif.disp_row = '0;
    bif.disp_col = '0;
    tick();
    tick();

    // reset values
    chk("rst_in_ready", bif.in_ready, 0);
    chk("rst_we", bif.ram_we, 0);
    chk("rst_wr_row", bif.ram_wr_row, 0);
    chk("rst_wr_col", bif.ram_wr_col, 0);
    chk("rst_wr_data", bif.ram_wr_data, 0);
    chk("rst_rd_row", bif.ram_rd_row, 0);
    chk("rst_rd_col", bif.ram_rd_col, 0);
    chk("rst_disp_valid", bif.disp_valid, 0);
    chk("rst_disp_pixel", bif.disp_pixel, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_frame_done", bif.frame_done, 0);
    chk("rst_frame_valid", bif.frame_valid, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    // idle: valid without start is not accepted, fetch is blanked
    rst = 1'b0;
    tick();
    chk("idle_in_ready", bif.in_ready, 0);
    chk("idle_we", bif.ram_we, 0);
    bif.disp_req = 1'b1;
    bif.disp_row = 8'd5;
    bif.disp_col = 9'd3;
    tick();
    bif.disp_req = 1'b0;
    chk("idle_rd_row", bif.ram_rd_row, 5);
    chk("idle_rd_col", bif.ram_rd_col, 3);
    tick();
    chk("idle_disp_valid", bif.disp_valid, 1);
    chk("idle_disp_blank", bif.disp_pixel, 12'h000);
    tick();
    chk("idle_disp_valid_off", bif.disp_valid, 0);
    bif.in_valid = 1'b0;

    // fill with gaps and a start pulse mid-frame that must be ignored
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    chk("fill_state", dbg_state, ST_FILL);
    chk("fill_in_ready", bif.in_ready, 1);
    chk("fill_busy", bif.busy, 1);
    chk("fill_frame_valid", bif.frame_valid, 0);
    run_fill(1'b1, NPIX, 1'b1, 1'b0, 12'h000);
    chk("last_state", dbg_state, ST_DONE);
    chk("last_in_ready", bif.in_ready, 0);
    chk("last_frame_valid", bif.frame_valid, 0);
    tick();
    chk("post_frame_done", bif.frame_done, 0);
    chk("post_frame_valid", bif.frame_valid, 1);
    chk("post_we", bif.ram_we, 0);
    chk("post_busy", bif.busy, 0);

    // back-to-back readback
    bif.disp_req = 1'b1;
    bif.disp_row = 8'd5;
    bif.disp_col = 9'd3;
    tick();
    bif.disp_row = 8'd2;
    bif.disp_col = 9'd7;
    tick();
    bif.disp_row = 8'd7;
    bif.disp_col = 9'd15;
    chk("rd_a_valid", bif.disp_valid, 1);
    chk("rd_a_pixel", bif.disp_pixel, 12'h503);
    tick();
    bif.disp_req = 1'b0;
    chk("rd_b_valid", bif.disp_valid, 1);
    chk("rd_b_pixel", bif.disp_pixel, 12'h207);
    tick();
    chk("rd_corner_pixel", bif.disp_pixel, 12'h70F);
    tick();
    chk("rd_idle_valid", bif.disp_valid, 0);
    chk("rd_idle_hold", bif.disp_pixel, 12'h70F);

    // out-of-range reads with a valid frame
    bif.disp_req = 1'b1;
    bif.disp_row = 8'd8;
    bif.disp_col = 9'd0;
    tick();
    bif.disp_row = 8'd0;
    bif.disp_col = 9'd16;
    tick();
    bif.disp_req = 1'b0;
    chk("oor_row_valid", bif.disp_valid, 1);
    chk("oor_row_pixel", bif.disp_pixel, 12'h000);
    tick();
    chk("oor_col_valid", bif.disp_valid, 1);
    chk("oor_col_pixel", bif.disp_pixel, 12'h000);
    tick();

    // restart and abandon mid-frame with an asynchronous reset
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    chk("restart_frame_valid", bif.frame_valid, 0);
    run_fill(1'b0, 20, 1'b0, 1'b0, 12'h0F0);
    rst = 1'b1;
    #1;
    chk("mrst_we", bif.ram_we, 0);
    chk("mrst_wr_row", bif.ram_wr_row, 0);
    chk("mrst_wr_col", bif.ram_wr_col, 0);
    chk("mrst_wr_data", bif.ram_wr_data, 0);
    chk("mrst_in_ready", bif.in_ready, 0);
    chk("mrst_frame_valid", bif.frame_valid, 0);
    chk("mrst_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();
    bif.disp_req = 1'b1;
    bif.disp_row = 8'd5;
    bif.disp_col = 9'd3;
    tick();
    bif.disp_req = 1'b0;
    tick();
    chk("mrst_read_blank", bif.disp_pixel, 12'h000);

    // full fill after reset; start arriving with the last beat is ignored
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    run_fill(1'b0, NPIX, 1'b0, 1'b1, 12'hFFF);
    chk("sim_last_state", dbg_state, ST_DONE);
    tick();
    chk("sim_frame_valid", bif.frame_valid, 1);
    chk("sim_state_done", dbg_state, ST_DONE);
    bif.disp_req = 1'b1;
    bif.disp_row = 8'd5;
    bif.disp_col = 9'd3;
    tick();
    bif.disp_req = 1'b0;
    tick();
    chk("f2_rd_pixel", bif.disp_pixel, 12'hAFC);

    // next start from DONE drops frame_valid
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    chk("f3_state", dbg_state, ST_FILL);
    chk("f3_in_ready", bif.in_ready, 1);
    chk("f3_frame_valid", bif.frame_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
